// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS decode/execute slice.
// Latency: n/a (constants, types and one helper only).
// Backpressure: n/a.
package mips_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // ALU-op classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Write-register select
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  // Writeback select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Decoded control bundle, registered as one unit
  typedef struct packed {
    logic [1:0] regdst;
    logic       regwrite;
    logic       branch;
    logic       jump;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic [1:0] memtoreg;
    logic [1:0] aluop;
  } ctrl_t;

  // Maps an R-type funct field to an ALU control code; unknown functs yield ALU_BAD
  function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_NOR:  return ALU_NOR;
      default: return ALU_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational MIPS ALU: add/sub/and/or/nor/slt plus a zero flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs.
module mips_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Select the operation; undefined codes (including ALU_BAD) produce 0
  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_exec.sv
// MIPS decode + execute stage: control decode, ALU-control decode, operand mux, ALU.
// Latency: 1 cycle; every output is registered on the rising clk edge.
// Backpressure: none; a new instruction is accepted every cycle.
module mips_decode_exec
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [1:0]       regdst,
  output logic             regwrite,
  output logic             branch,
  output logic             jump,
  output logic             memread,
  output logic             memwrite,
  output logic             alusrc,
  output logic [1:0]       memtoreg,
  output logic [1:0]       aluop,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [15:0]      imm;
  logic             unused_instr_bits;

  ctrl_t            ctrl_d, ctrl_q;
  logic [3:0]       alu_ctrl_d, alu_ctrl_q;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic             zero_d, zero_q;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  // Register specifiers are consumed by the register file, not this stage
  assign unused_instr_bits = ^instr[25:16];

  // Opcode decode into the control bundle; unknown opcodes leave everything at 0
  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_d.regdst   = REGDST_RD;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.memtoreg = WB_MEM;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.memread  = 1'b1;
        ctrl_d.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.memwrite = 1'b1;
        ctrl_d.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.aluop  = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.aluop    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.jump     = 1'b1;
        ctrl_d.regdst   = REGDST_R31;
        ctrl_d.memtoreg = WB_PC4;
        ctrl_d.regwrite = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // ALU-control decode from the op class, falling through to funct for R-type
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    case (ctrl_d.aluop)
      ALUOP_ADD:   alu_ctrl_d = ALU_ADD;
      ALUOP_SUB:   alu_ctrl_d = ALU_SUB;
      ALUOP_FUNCT: alu_ctrl_d = funct_to_alu(funct);
      default:     alu_ctrl_d = ALU_ADD;
    endcase
  end

  // Operand B: register value, or sign-extended immediate for memory/immediate ops
  always_comb begin
    opb = rt_data;
    if (ctrl_d.alusrc) opb = {{(WIDTH-16){imm[15]}}, imm};
  end

  mips_alu #(.WIDTH(WIDTH)) u_alu (
    .alu_ctrl (alu_ctrl_d),
    .a        (rs_data),
    .b        (opb),
    .result   (alu_result_d),
    .zero     (zero_d)
  );

  // Output register; reset wins over any instruction presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      alu_ctrl_q   <= '0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
    end
  end

  assign regdst     = ctrl_q.regdst;
  assign regwrite   = ctrl_q.regwrite;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign memread    = ctrl_q.memread;
  assign memwrite   = ctrl_q.memwrite;
  assign alusrc     = ctrl_q.alusrc;
  assign memtoreg   = ctrl_q.memtoreg;
  assign aluop      = ctrl_q.aluop;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_result = alu_result_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed bench for mips_decode_exec with hand-computed expected values.
// Latency: each vector is checked one rising edge after it is applied.
// Backpressure: none; vectors are applied back-to-back.
module tb_mips_decode_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [1:0]  regdst;
  logic        regwrite, branch, jump, memread, memwrite, alusrc;
  logic [1:0]  memtoreg;
  logic [1:0]  aluop;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_decode_exec #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .branch     (branch),
    .jump       (jump),
    .memread    (memread),
    .memwrite   (memwrite),
    .alusrc     (alusrc),
    .memtoreg   (memtoreg),
    .aluop      (aluop),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero       (zero)
  );

  // Packs expected control flags in the order {regdst, regwrite, branch, jump, memread, memwrite, alusrc, memtoreg, aluop}
  function automatic logic [11:0] ctl(input logic [1:0] rd, input logic rw, input logic br,
                                      input logic jp, input logic mr, input logic mw,
                                      input logic as, input logic [1:0] mt, input logic [1:0] ao);
    return {rd, rw, br, jp, mr, mw, as, mt, ao};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply a vector, then sample one edge later away from the edge
  task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr   = i;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [11:0] c, input logic [3:0] ac,
                            input logic [31:0] res, input logic z);
    chk({tag, ".ctrl"}, {20'h0, regdst, regwrite, branch, jump, memread, memwrite,
                         alusrc, memtoreg, aluop}, {20'h0, c});
    chk({tag, ".alu_ctrl"}, {28'h0, alu_ctrl}, {28'h0, ac});
    chk({tag, ".result"}, alu_result, res);
    chk({tag, ".zero"}, {31'h0, zero}, {31'h0, z});
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    @(posedge clk); #1;
    step(32'h0000_0020, 32'd5, 32'd7);
    expect_all("reset", 12'h000, 4'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // R-type add 5+7
    step(32'h0000_0020, 32'd5, 32'd7);
    expect_all("add", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b0010, 32'd12, 1'b0);

    // R-type sub, equal operands
    step(32'h0000_0022, 32'd7, 32'd7);
    expect_all("sub", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b0110, 32'd0, 1'b1);

    // R-type and / or / nor
    step(32'h0000_0024, 32'h0000_F0F0, 32'h0000_FF00);
    expect_all("and", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b0000, 32'h0000_F000, 1'b0);
    step(32'h0000_0025, 32'h0000_F0F0, 32'h0000_FF00);
    expect_all("or", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b0001, 32'h0000_FFF0, 1'b0);
    step(32'h0000_0027, 32'h0000_F0F0, 32'h0000_FF00);
    expect_all("nor", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b1100, 32'hFFFF_000F, 1'b0);

    // R-type unknown funct gives 1111 and a zero result
    step(32'h0000_003F, 32'd3, 32'd4);
    expect_all("badfn", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b1111, 32'd0, 1'b1);

    // beq with equal operands
    step(32'h1000_0000, 32'h0000_1234, 32'h0000_1234);
    expect_all("beq", ctl(2'b00,0,1,0,0,0,0,2'b00,2'b01), 4'b0110, 32'd0, 1'b1);

    // lw with negative immediate: 0x100 + (-4)
    step(32'h8C00_FFFC, 32'h0000_0100, 32'hDEAD_BEEF);
    expect_all("lw", ctl(2'b00,1,0,0,1,0,1,2'b01,2'b00), 4'b0010, 32'h0000_00FC, 1'b0);

    // sw with positive immediate
    step(32'hAC00_0010, 32'h0000_0020, 32'h1111_1111);
    expect_all("sw", ctl(2'b00,0,0,0,0,1,1,2'b00,2'b00), 4'b0010, 32'h0000_0030, 1'b0);

    // addi with largest positive immediate
    step(32'h2000_7FFF, 32'h0000_0001, 32'h0);
    expect_all("addi", ctl(2'b00,1,0,0,0,0,1,2'b00,2'b00), 4'b0010, 32'h0000_8000, 1'b0);

    // slt signed: -1 < 1, then 1 < -1
    step(32'h0000_002A, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_all("slt_neg", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b0111, 32'd1, 1'b0);
    step(32'h0000_002A, 32'h0000_0001, 32'hFFFF_FFFF);
    expect_all("slt_pos", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b0111, 32'd0, 1'b1);

    // jal and j control flags
    step(32'h0C00_0000, 32'd0, 32'd0);
    chk("jal.ctrl", {20'h0, regdst, regwrite, branch, jump, memread, memwrite, alusrc, memtoreg, aluop},
        {20'h0, ctl(2'b10,1,0,1,0,0,0,2'b10,2'b00)});
    step(32'h0800_0000, 32'd0, 32'd0);
    chk("j.ctrl", {20'h0, regdst, regwrite, branch, jump, memread, memwrite, alusrc, memtoreg, aluop},
        {20'h0, ctl(2'b00,0,0,1,0,0,0,2'b00,2'b00)});

    // Unknown opcode: every control flag low
    step(32'hFC00_0020, 32'd9, 32'd9);
    chk("unk.ctrl", {20'h0, regdst, regwrite, branch, jump, memread, memwrite, alusrc, memtoreg, aluop},
        32'h0);

    // Reset during R-type nor 0,0 clears everything, release yields all ones
    rst = 1'b1;
    step(32'h0000_0027, 32'd0, 32'd0);
    expect_all("rst_nor", 12'h000, 4'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step(32'h0000_0027, 32'd0, 32'd0);
    expect_all("post_rst", ctl(2'b01,1,0,0,0,0,0,2'b00,2'b10), 4'b1100, 32'hFFFF_FFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
